counter_sweep_ctrl: RTL and testbench
=====================================

// Module: counter_sweep_ctrl
// PURPOSE
//  Upstream sequencer for the counter block. Drives its reset, preload, up_dn,
//  delta and pl_data inputs through a programmed sweep: delta steps from
//  cfg_delta_start to cfg_delta_end. Each delta value is held for cfg_dwell
//  clocks. Replaces hand-written stimulus with a repeatable hardware sweep for
//  freq_out characterisation.
// PARAMETERS
//  DELTA_W  4   width of delta / step fields (matches counter delta)
//  DATA_W   8   width of pl_data (matches counter pl_data)
//  DWELL_W  16  width of dwell cycle counter
//  RST_CYC  3   clocks ctr_reset is held high at sweep start
// PORTS
//  clk              in   1        single clock, rising edge
//  reset_n          in   1        asynchronous, active-low reset
//  start            in   1        level; sampled only in IDLE; starts a sweep
//  abort            in   1        level; terminates the sweep, any state
//  cfg_delta_start  in   DELTA_W  first delta value
//  cfg_delta_end    in   DELTA_W  last delta value (bound, inclusive)
//  cfg_delta_step   in   DELTA_W  increment magnitude; direction = sign(end-start)
//  cfg_dwell        in   DWELL_W  clocks per delta value; 0 treated as 1
//  cfg_up_dn        in   1        passed to counter up_dn for whole sweep
//  cfg_preload_en   in   1        issue a 1-cycle preload before each dwell
//  cfg_pl_data      in   DATA_W   preload value
//  cfg_loop         in   1        restart sweep after last step instead of DONE
//  ctr_reset        out  1        active-high reset to counter
//  preload          out  1        counter preload strobe
//  up_dn            out  1        counter direction
//  delta            out  DELTA_W  counter step size
//  pl_data          out  DATA_W   counter preload data
//  busy             out  1        sweep in progress
//  done             out  1        1-cycle pulse at normal sweep completion
// BEHAVIOUR
//  - Reset: state=IDLE; ctr_reset=1, preload=0, up_dn=1, delta=0, pl_data=0,
//    busy=0, done=0. All outputs are registered.
//  - All cfg_* inputs are latched on the edge that accepts start. Later changes
//    have no effect until the next start.
//  - FSM: IDLE -> RST -> (PRE) -> DWELL -> {PRE|DWELL next delta | RST (loop) | IDLE}.
//  - IDLE: ctr_reset=1, busy=0. When start=1 and abort=0, go to RST with
//    busy=1 and delta=cfg_delta_start.
//  - RST: ctr_reset=1 for exactly RST_CYC clocks, then go to PRE if
//    cfg_preload_en=1, else go to DWELL.
//  - PRE: one clock with preload=1 and pl_data=cfg_pl_data; then go to DWELL.
//    preload=0 in every other state.
//  - DWELL: ctr_reset=0; delta is constant for max(cfg_dwell,1) clocks.
//  - End of dwell, when delta has not reached the last value: delta advances
//    by step on the same edge (no gap clock) and the FSM goes to PRE or DWELL.
//  - Last value: next = delta +/- step would pass cfg_delta_end, or would leave
//    the 0..2^DELTA_W-1 range, or step==0, or start==end.
//    The overshoot value is never driven.
//  - After the last value: cfg_loop=1 -> go to RST with delta=start, done not
//    pulsed. Otherwise -> go to IDLE with done=1 for one clock and busy=0.
//  - Descending sweep (start>end): delta decrements; up_dn still = cfg_up_dn.
//  - abort=1 in any non-IDLE state: next edge enters IDLE; ctr_reset=1;
//    delta holds its last value; done is not pulsed. abort has priority over
//    start.
//  - start while busy is ignored. reset_n low mid-sweep restores reset values
//    immediately.
// STRUCTURE
//  - counter_pkg: DELTA_W/DATA_W defaults and the sweep_state_e encoding
//    (IDLE, RST, PRE, DWELL). Shared with the counter and benches.
//  - Sub-module dwell_timer: loadable DWELL_W down-counter with load and
//    expire outputs. Reused for RST_CYC timing.
//  - Remaining logic is the top-level FSM and the config latch.
// TESTING
//  1 Basic sweep: start=1..5, step=1, dwell=1000, preload off -> ctr_reset
//    high 3 clocks, delta 1,2,3,4,5 each held exactly 1000 clocks; done pulses
//    once, 5003 clocks after the start edge.
//  2 Overshoot: start=1, end=6, step=2 -> delta 1,3,5 only; done after 3
//    dwells; delta never equals 7.
//  3 Descending with preload: start=9, end=3, step=3, preload_en=1,
//    pl_data=8'hA5 -> delta 9,6,3; preload=1 for exactly one clock before each
//    dwell with pl_data=A5.
//  4 Edge cases: dwell=0 -> 1 clock per value. step=0 -> single dwell at
//    start, then done. start=15, end=15 -> single value.
//  5 Loop and abort: cfg_loop=1 -> RST re-entered after the last value with
//    no done pulse; abort mid-DWELL -> IDLE next clock, ctr_reset=1, busy=0,
//    done=0.
//  6 Robustness: start while busy and cfg changes mid-sweep -> no effect;
//    reset_n low mid-sweep -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared definitions for the counter sweep sequencer: default field widths,
// the reset hold length and the sweep FSM state encoding.
package counter_sweep_ctrl_pkg;

    localparam int DELTA_W_DEF = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int DWELL_W_DEF = 16;
    localparam int RST_CYC_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RST   = 2'd1,
        PRE   = 2'd2,
        DWELL = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// Sweep control bundle: start/abort and sweep configuration going into the
// sequencer, counter drive signals and status coming back out.
interface counter_sweep_ctrl_if
    import counter_sweep_ctrl_pkg::*;
#(
    parameter int DELTA_W = DELTA_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
);

    logic               start;
    logic               abort;
    logic [DELTA_W-1:0] cfg_delta_start;
    logic [DELTA_W-1:0] cfg_delta_end;
    logic [DELTA_W-1:0] cfg_delta_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_up_dn;
    logic               cfg_preload_en;
    logic [DATA_W-1:0]  cfg_pl_data;
    logic               cfg_loop;

    logic               ctr_reset;
    logic               preload;
    logic               up_dn;
    logic [DELTA_W-1:0] delta;
    logic [DATA_W-1:0]  pl_data;
    logic               busy;
    logic               done;

    // The side that requests sweeps and watches the counter drive
    modport master (
        output start, abort,
        output cfg_delta_start, cfg_delta_end, cfg_delta_step, cfg_dwell,
        output cfg_up_dn, cfg_preload_en, cfg_pl_data, cfg_loop,
        input  ctr_reset, preload, up_dn, delta, pl_data, busy, done
    );

    // The sequencer itself
    modport slave (
        input  start, abort,
        input  cfg_delta_start, cfg_delta_end, cfg_delta_step, cfg_dwell,
        input  cfg_up_dn, cfg_preload_en, cfg_pl_data, cfg_loop,
        output ctr_reset, preload, up_dn, delta, pl_data, busy, done
    );

endinterface

// File: rtl/counter_sweep_ctrl_dwell_timer.sv
// Loadable down-counter used to time both the counter reset hold and each
// dwell interval. Loading N gives an interval of N clocks starting on the
// clock after the load edge; expire is high in the last clock of the interval.
// Loading 0 behaves like loading 1.
module counter_sweep_ctrl_dwell_timer
    import counter_sweep_ctrl_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_value,
    output logic               expire
);

    logic [DWELL_W-1:0] count;

    // Reload on request, otherwise count down and park at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count <= DWELL_W'(1));

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Counter sweep sequencer. Holds the counter in reset, optionally preloads it,
// then steps delta from the configured start value towards the end value,
// holding each value for a programmed number of clocks. All outputs are
// registered so the counter sees clean, glitch-free drive.
module counter_sweep_ctrl
    import counter_sweep_ctrl_pkg::*;
#(
    parameter int DELTA_W = DELTA_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int RST_CYC = RST_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    counter_sweep_ctrl_if.slave  bus
);

    sweep_state_e       state, state_nxt;

    logic [DELTA_W-1:0] start_q, end_q, step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               preload_en_q, loop_q, desc_q;
    logic [DATA_W-1:0]  pl_cfg_q;

    logic               ctr_reset_q, ctr_reset_nxt;
    logic               preload_q, preload_nxt;
    logic               up_dn_q, up_dn_nxt;
    logic [DELTA_W-1:0] delta_q, delta_nxt;
    logic [DATA_W-1:0]  pl_data_q, pl_data_nxt;
    logic               busy_q, busy_nxt;
    logic               done_q, done_nxt;

    logic               latch_cfg;
    logic               timer_load;
    logic [DWELL_W-1:0] timer_value;
    logic               timer_expire;

    logic [DELTA_W:0]   sum_ext;
    logic [DELTA_W-1:0] delta_adv;
    logic               is_last;

    counter_sweep_ctrl_dwell_timer #(
        .DWELL_W    (DWELL_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .expire     (timer_expire)
    );

    // Next delta value and whether the current one is the last of the sweep;
    // the extra sum bit catches wrap past the top of the delta range
    always_comb begin
        sum_ext   = {1'b0, delta_q} + {1'b0, step_q};
        delta_adv = desc_q ? (delta_q - step_q) : sum_ext[DELTA_W-1:0];
        if ((step_q == '0) || (delta_q == end_q)) begin
            is_last = 1'b1;
        end else if (desc_q) begin
            is_last = (delta_q < step_q) || ((delta_q - step_q) < end_q);
        end else begin
            is_last = (sum_ext > {1'b0, end_q});
        end
    end

    // Sweep FSM: next state plus next value of every registered output
    always_comb begin
        state_nxt     = state;
        ctr_reset_nxt = ctr_reset_q;
        preload_nxt   = 1'b0;
        up_dn_nxt     = up_dn_q;
        delta_nxt     = delta_q;
        pl_data_nxt   = pl_data_q;
        busy_nxt      = busy_q;
        done_nxt      = 1'b0;
        latch_cfg     = 1'b0;
        timer_load    = 1'b0;
        timer_value   = DWELL_W'(RST_CYC);

        if ((state != IDLE) && bus.abort) begin
            state_nxt     = IDLE;
            ctr_reset_nxt = 1'b1;
            busy_nxt      = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ctr_reset_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                    if (bus.start && !bus.abort) begin
                        state_nxt   = RST;
                        latch_cfg   = 1'b1;
                        busy_nxt    = 1'b1;
                        delta_nxt   = bus.cfg_delta_start;
                        up_dn_nxt   = bus.cfg_up_dn;
                        timer_load  = 1'b1;
                        timer_value = DWELL_W'(RST_CYC);
                    end
                end
                RST: begin
                    if (timer_expire) begin
                        ctr_reset_nxt = 1'b0;
                        if (preload_en_q) begin
                            state_nxt   = PRE;
                            preload_nxt = 1'b1;
                            pl_data_nxt = pl_cfg_q;
                        end else begin
                            state_nxt   = DWELL;
                            timer_load  = 1'b1;
                            timer_value = dwell_q;
                        end
                    end
                end
                PRE: begin
                    state_nxt   = DWELL;
                    timer_load  = 1'b1;
                    timer_value = dwell_q;
                end
                DWELL: begin
                    if (timer_expire) begin
                        if (!is_last) begin
                            delta_nxt = delta_adv;
                            if (preload_en_q) begin
                                state_nxt   = PRE;
                                preload_nxt = 1'b1;
                                pl_data_nxt = pl_cfg_q;
                            end else begin
                                timer_load  = 1'b1;
                                timer_value = dwell_q;
                            end
                        end else if (loop_q) begin
                            state_nxt     = RST;
                            delta_nxt     = start_q;
                            ctr_reset_nxt = 1'b1;
                            timer_load    = 1'b1;
                            timer_value   = DWELL_W'(RST_CYC);
                        end else begin
                            state_nxt     = IDLE;
                            ctr_reset_nxt = 1'b1;
                            busy_nxt      = 1'b0;
                            done_nxt      = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt     = IDLE;
                    ctr_reset_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset leaves the counter held in reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ctr_reset_q <= 1'b1;
            preload_q   <= 1'b0;
            up_dn_q     <= 1'b1;
            delta_q     <= '0;
            pl_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            ctr_reset_q <= ctr_reset_nxt;
            preload_q   <= preload_nxt;
            up_dn_q     <= up_dn_nxt;
            delta_q     <= delta_nxt;
            pl_data_q   <= pl_data_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
        end
    end

    // Config latch: the whole sweep setup is frozen on the edge accepting start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q      <= '0;
            end_q        <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            preload_en_q <= 1'b0;
            loop_q       <= 1'b0;
            desc_q       <= 1'b0;
            pl_cfg_q     <= '0;
        end else if (latch_cfg) begin
            start_q      <= bus.cfg_delta_start;
            end_q        <= bus.cfg_delta_end;
            step_q       <= bus.cfg_delta_step;
            dwell_q      <= bus.cfg_dwell;
            preload_en_q <= bus.cfg_preload_en;
            loop_q       <= bus.cfg_loop;
            desc_q       <= (bus.cfg_delta_start > bus.cfg_delta_end);
            pl_cfg_q     <= bus.cfg_pl_data;
        end
    end

    assign bus.ctr_reset = ctr_reset_q;
    assign bus.preload   = preload_q;
    assign bus.up_dn     = up_dn_q;
    assign bus.delta     = delta_q;
    assign bus.pl_data   = pl_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Self-checking bench for the counter sweep sequencer. A table of sweep
// setups with hand-computed delta sequences is walked clock by clock, then
// loop/abort, start-while-busy and asynchronous reset are exercised by hand.
module tb_counter_sweep_ctrl;
    import counter_sweep_ctrl_pkg::*;

    localparam int DELTA_W = 4;
    localparam int DATA_W  = 8;
    localparam int DWELL_W = 16;
    localparam int RST_CYC = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   assertions = 0;
    int   failures = 0;

    counter_sweep_ctrl_if #(
        .DELTA_W (DELTA_W),
        .DATA_W  (DATA_W),
        .DWELL_W (DWELL_W)
    ) bus ();

    counter_sweep_ctrl #(
        .DELTA_W (DELTA_W),
        .DATA_W  (DATA_W),
        .DWELL_W (DWELL_W),
        .RST_CYC (RST_CYC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // One sweep setup plus the expected delta sequence (nibble i = value i)
    typedef struct {
        string       name;
        logic [3:0]  d_start;
        logic [3:0]  d_end;
        logic [3:0]  d_step;
        logic [15:0] dwell;
        logic        up_dn;
        logic        pre_en;
        logic [7:0]  pl;
        int          n_vals;
        logic [31:0] vals;
    } sweep_vec_t;

    sweep_vec_t vecs[$];

    function automatic sweep_vec_t mkVec(input string name, input logic [3:0] s, input logic [3:0] e,
                                         input logic [3:0] st, input logic [15:0] dw, input logic up,
                                         input logic pre, input logic [7:0] pl, input int n,
                                         input logic [31:0] vals);
        sweep_vec_t v;
        v.name = name; v.d_start = s; v.d_end = e; v.d_step = st; v.dwell = dw;
        v.up_dn = up; v.pre_en = pre; v.pl = pl; v.n_vals = n; v.vals = vals;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkCycle(input string tag, input logic e_rst, input logic e_pre, input logic e_up,
                              input logic [3:0] e_delta, input logic e_busy, input logic e_done);
        checkOutput({tag, ".ctr_reset"}, 32'(bus.ctr_reset), 32'(e_rst));
        checkOutput({tag, ".preload"},   32'(bus.preload),   32'(e_pre));
        checkOutput({tag, ".up_dn"},     32'(bus.up_dn),     32'(e_up));
        checkOutput({tag, ".delta"},     32'(bus.delta),     32'(e_delta));
        checkOutput({tag, ".busy"},      32'(bus.busy),      32'(e_busy));
        checkOutput({tag, ".done"},      32'(bus.done),      32'(e_done));
    endtask

    task automatic checkReset(input string tag);
        checkCycle(tag, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        checkOutput({tag, ".pl_data"}, 32'(bus.pl_data), 32'h0);
    endtask

    task automatic applyStimulus(input sweep_vec_t v, input logic loop);
        bus.cfg_delta_start = v.d_start;
        bus.cfg_delta_end   = v.d_end;
        bus.cfg_delta_step  = v.d_step;
        bus.cfg_dwell       = v.dwell;
        bus.cfg_up_dn       = v.up_dn;
        bus.cfg_preload_en  = v.pre_en;
        bus.cfg_pl_data     = v.pl;
        bus.cfg_loop        = loop;
        bus.start           = 1'b1;
    endtask

    // Scramble start and every cfg input while a sweep is running
    task automatic disturbInputs();
        bus.start           = 1'b1;
        bus.cfg_delta_start = 4'($urandom);
        bus.cfg_delta_end   = 4'($urandom);
        bus.cfg_delta_step  = 4'($urandom);
        bus.cfg_dwell       = 16'($urandom_range(0, 7));
        bus.cfg_up_dn       = 1'($urandom);
        bus.cfg_preload_en  = 1'($urandom);
        bus.cfg_pl_data     = 8'($urandom);
        bus.cfg_loop        = 1'($urandom);
    endtask

    // Start one non-looping sweep and check every clock up to the idle after done
    task automatic runSweep(input sweep_vec_t v, input bit disturb);
        int dw;
        logic [3:0] val;
        dw = (v.dwell == 16'd0) ? 1 : int'(v.dwell);
        @(negedge clk);
        applyStimulus(v, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < RST_CYC; c++) begin
            checkCycle({v.name, "/rst"}, 1'b1, 1'b0, v.up_dn, v.vals[3:0], 1'b1, 1'b0);
            if (disturb) disturbInputs();
            @(negedge clk);
        end
        for (int i = 0; i < v.n_vals; i++) begin
            val = v.vals[i*4 +: 4];
            if (v.pre_en) begin
                checkCycle({v.name, "/pre"}, 1'b0, 1'b1, v.up_dn, val, 1'b1, 1'b0);
                checkOutput({v.name, "/pre.pl_data"}, 32'(bus.pl_data), 32'(v.pl));
                if (disturb) disturbInputs();
                @(negedge clk);
            end
            for (int c = 0; c < dw; c++) begin
                checkCycle({v.name, "/dwell"}, 1'b0, 1'b0, v.up_dn, val, 1'b1, 1'b0);
                if (disturb) disturbInputs();
                @(negedge clk);
            end
        end
        bus.start = 1'b0;
        val = v.vals[(v.n_vals-1)*4 +: 4];
        checkCycle({v.name, "/done"}, 1'b1, 1'b0, v.up_dn, val, 1'b0, 1'b1);
        @(negedge clk);
        checkCycle({v.name, "/after"}, 1'b1, 1'b0, v.up_dn, val, 1'b0, 1'b0);
    endtask

    initial begin
        sweep_vec_t lv;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cfg_delta_start = '0;
        bus.cfg_delta_end   = '0;
        bus.cfg_delta_step  = '0;
        bus.cfg_dwell       = '0;
        bus.cfg_up_dn       = 1'b0;
        bus.cfg_preload_en  = 1'b0;
        bus.cfg_pl_data     = '0;
        bus.cfg_loop        = 1'b0;

        vecs.push_back(mkVec("basic",      4'd1,  4'd5,  4'd1, 16'd1000, 1'b1, 1'b0, 8'h00, 5, 32'h00054321));
        vecs.push_back(mkVec("overshoot",  4'd1,  4'd6,  4'd2, 16'd4,    1'b1, 1'b0, 8'h00, 3, 32'h00000531));
        vecs.push_back(mkVec("desc_pre",   4'd9,  4'd3,  4'd3, 16'd5,    1'b1, 1'b1, 8'hA5, 3, 32'h00000369));
        vecs.push_back(mkVec("dwell0",     4'd2,  4'd4,  4'd1, 16'd0,    1'b0, 1'b0, 8'h00, 3, 32'h00000432));
        vecs.push_back(mkVec("step0",      4'd7,  4'd12, 4'd0, 16'd3,    1'b1, 1'b0, 8'h00, 1, 32'h00000007));
        vecs.push_back(mkVec("same_ends",  4'd15, 4'd15, 4'd1, 16'd2,    1'b0, 1'b1, 8'h5A, 1, 32'h0000000F));
        vecs.push_back(mkVec("top_range",  4'd12, 4'd15, 4'd4, 16'd2,    1'b1, 1'b0, 8'h00, 1, 32'h0000000C));
        vecs.push_back(mkVec("desc_floor", 4'd5,  4'd0,  4'd2, 16'd3,    1'b0, 1'b1, 8'h3C, 3, 32'h00000135));
        vecs.push_back(mkVec("dwell0_pre", 4'd14, 4'd15, 4'd1, 16'd0,    1'b1, 1'b1, 8'hC3, 2, 32'h000000FE));

        // Power-on reset, asynchronous
        #2 reset_n = 1'b0;
        #1 checkReset("por");
        @(negedge clk);
        @(negedge clk);
        checkReset("por_held");
        reset_n = 1'b1;
        @(negedge clk);
        checkReset("idle");

        foreach (vecs[i]) begin
            $display("[TB] sweep %s", vecs[i].name);
            runSweep(vecs[i], 1'b0);
        end

        $display("[TB] start and cfg changes while busy");
        runSweep(vecs[1], 1'b1);

        $display("[TB] loop then abort");
        lv = mkVec("loop", 4'd1, 4'd2, 4'd1, 16'd2, 1'b1, 1'b0, 8'h00, 2, 32'h00000021);
        @(negedge clk);
        applyStimulus(lv, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < RST_CYC; c++) begin
            checkCycle("loop/rst1", 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
            @(negedge clk);
        end
        for (int c = 0; c < 4; c++) begin
            checkCycle("loop/dwell", 1'b0, 1'b0, 1'b1, (c < 2) ? 4'd1 : 4'd2, 1'b1, 1'b0);
            @(negedge clk);
        end
        for (int c = 0; c < RST_CYC; c++) begin
            checkCycle("loop/rst2", 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
            @(negedge clk);
        end
        checkCycle("loop/dwell2", 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
        bus.abort = 1'b1;
        @(negedge clk);
        checkCycle("abort", 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        bus.abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkCycle("abort/idle", 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        end

        $display("[TB] abort beats start in idle");
        applyStimulus(vecs[0], 1'b0);
        bus.abort = 1'b1;
        @(negedge clk);
        checkCycle("abort_prio", 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        checkCycle("abort_prio/idle", 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);

        $display("[TB] reset mid-sweep");
        applyStimulus(vecs[7], 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        checkCycle("midrst/pre", 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0);
        checkOutput("midrst/pre.pl_data", 32'(bus.pl_data), 32'h3C);
        #2 reset_n = 1'b0;
        #1 checkReset("midrst/async");
        @(negedge clk);
        checkReset("midrst/held");
        reset_n = 1'b1;
        @(negedge clk);
        checkReset("midrst/idle");

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
